// File: rtl/attribute_f2x_scheduler.sv
// attribute_f2x_scheduler: round-robin packet arbiter sharing one float-to-fixed converter, with a credit-guarded FWFT result FIFO
module attribute_f2x_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int CONV_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic                  s0_tlast,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic                  s1_tlast,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  output logic                  m_conv_tvalid,
  output logic                  m_conv_tlast,
  output logic                  m_conv_tid,
  output logic [DATA_WIDTH-1:0] m_conv_tdata,
  input  logic                  s_conv_tvalid,
  input  logic                  s_conv_tlast,
  input  logic                  s_conv_tid,
  input  logic [DATA_WIDTH-1:0] s_conv_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CONV_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state, state_nx;
  logic last_grant, g_vld, g_id, credit, xfer, sel_last, conv_in, rd_en, wr_en, full;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CW-1:0] wr_ptr, rd_ptr, count, inflight;
  logic [BW-1:0] blank;
  logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];

  assign count         = wr_ptr - rd_ptr;
  assign full          = count == CW'(FIFO_DEPTH);
  assign m_axis_tvalid = count != '0;
  assign rd_en         = m_axis_tvalid & m_axis_tready;
  assign conv_in       = s_conv_tvalid & (blank == '0);
  assign wr_en         = conv_in & (~full | rd_en);
  assign {m_axis_tlast, m_axis_tid, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

  // grant selection, credit check, handshake and next arbiter state
  always_comb begin
    g_vld     = (state != IDLE) | s0_tvalid | s1_tvalid;
    g_id      = state == LOCK1 ? 1'b1 : state == LOCK0 ? 1'b0 :
                (s0_tvalid & s1_tvalid) ? ~last_grant : s1_tvalid;
    credit    = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    s0_tready = resetn & credit & g_vld & ~g_id;
    s1_tready = resetn & credit & g_vld & g_id;
    xfer      = (s0_tready & s0_tvalid) | (s1_tready & s1_tvalid);
    sel_last  = g_id ? s1_tlast : s0_tlast;
    sel_data  = g_id ? s1_tdata : s0_tdata;
    state_nx  = !xfer ? state : sel_last ? IDLE : g_id ? LOCK1 : LOCK0;
  end

  // arbiter state and round-robin history
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      last_grant <= (xfer & sel_last) ? g_id : last_grant;
    end
  end

  // registered issue port into the converter
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_conv_tvalid <= 1'b0;
      m_conv_tlast  <= 1'b0;
      m_conv_tid    <= 1'b0;
      m_conv_tdata  <= '0;
    end else begin
      m_conv_tvalid <= xfer;
      if (xfer) begin
        m_conv_tlast <= sel_last;
        m_conv_tid   <= g_id;
        m_conv_tdata <= sel_data;
      end
    end
  end

  // fragments inside the converter, and post-reset blanking of stale converter results
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      inflight <= '0;
      blank    <= BW'(CONV_LATENCY);
    end else begin
      inflight <= inflight + CW'(xfer) - CW'(conv_in);
      if (blank != '0) blank <= blank - BW'(1);
    end
  end

  // FIFO pointers and sticky overflow on a write that finds no room
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + CW'(wr_en);
      rd_ptr <= rd_ptr + CW'(rd_en);
      if (conv_in & full & ~rd_en) overflow <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_conv_tlast, s_conv_tid, s_conv_tdata};
  end
endmodule

// File: tb/tb_attribute_f2x_scheduler.sv
// tb_attribute_f2x_scheduler: table vectors, directed corner sequences and random traffic against a queue-based reference model
module tb_attribute_f2x_scheduler;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int D  = 8;

  logic aclk = 1'b0, resetn = 1'b0;
  logic s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0, m_axis_tready = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic s0_tready, s1_tready, m_conv_tvalid, m_conv_tlast, m_conv_tid;
  logic [DW-1:0] m_conv_tdata, s_conv_tdata, m_axis_tdata;
  logic s_conv_tvalid, s_conv_tlast, s_conv_tid, m_axis_tvalid, m_axis_tlast, m_axis_tid, overflow;

  always #5 aclk = ~aclk;

  attribute_f2x_scheduler #(.DATA_WIDTH(DW), .CONV_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .aclk(aclk), .resetn(resetn),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata),
    .m_conv_tvalid(m_conv_tvalid), .m_conv_tlast(m_conv_tlast), .m_conv_tid(m_conv_tid), .m_conv_tdata(m_conv_tdata),
    .s_conv_tvalid(s_conv_tvalid), .s_conv_tlast(s_conv_tlast), .s_conv_tid(s_conv_tid), .s_conv_tdata(s_conv_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdata(m_axis_tdata), .overflow(overflow)
  );

  // converter stand-in: fixed L-cycle pipeline that inverts the payload, never reset
  logic [DW+2:0] pipe [L] = '{default: '0};
  always @(posedge aclk) begin
    pipe[0] <= {m_conv_tvalid, m_conv_tlast, m_conv_tid, ~m_conv_tdata};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign {s_conv_tvalid, s_conv_tlast, s_conv_tid, s_conv_tdata} = pipe[L-1];

  typedef struct {
    logic          last;
    logic          id;
    logic [DW-1:0] data;
    int            avail;
  } frag_t;

  typedef struct packed {
    logic s0v, s0l, s1v, s1l, e0, e1;
  } vec_t;

  frag_t q[$];
  frag_t mc;
  logic mc_v = 1'b0, mlast = 1'b1;
  int mlock = -1, ecount = 0, n_chk = 0, n_fail = 0;
  logic obs_acc, obs_mv;
  int cyc;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, ecount);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mc_v  = 1'b0;
    mlock = -1;
    mlast = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s0_tready", DW'(s0_tready), '0);
    chk("rst_s1_tready", DW'(s1_tready), '0);
    chk("rst_m_axis_tvalid", DW'(m_axis_tvalid), '0);
    chk("rst_m_conv_tvalid", DW'(m_conv_tvalid), '0);
    chk("rst_m_conv_tlast", DW'(m_conv_tlast), '0);
    chk("rst_m_conv_tid", DW'(m_conv_tid), '0);
    chk("rst_m_conv_tdata", m_conv_tdata, '0);
    chk("rst_overflow", DW'(overflow), '0);
  endtask

  // one clock: predict from the model, compare, then advance the model across the edge
  task automatic cycle(input bit tchk = 1'b0, input logic te0 = 1'b0, input logic te1 = 1'b0);
    int g;
    logic cr, e0, e1, ev, a0, a1, pop, l0, l1;
    logic [DW-1:0] d0, d1;
    frag_t f;
    #1;
    g = -1;
    if (mlock >= 0) g = mlock;
    else if (s0_tvalid && s1_tvalid) g = 1 - int'(mlast);
    else if (s0_tvalid) g = 0;
    else if (s1_tvalid) g = 1;
    cr = q.size() < D;
    e0 = resetn && cr && g == 0;
    e1 = resetn && cr && g == 1;
    ev = q.size() > 0 && q[0].avail <= ecount;
    chk("s0_tready", DW'(s0_tready), DW'(e0));
    chk("s1_tready", DW'(s1_tready), DW'(e1));
    chk("m_axis_tvalid", DW'(m_axis_tvalid), DW'(ev));
    chk("overflow", DW'(overflow), '0);
    chk("m_conv_tvalid", DW'(m_conv_tvalid), DW'(mc_v));
    if (ev) begin
      chk("m_axis_tdata", m_axis_tdata, ~q[0].data);
      chk("m_axis_tid", DW'(m_axis_tid), DW'(q[0].id));
      chk("m_axis_tlast", DW'(m_axis_tlast), DW'(q[0].last));
    end
    if (mc_v) begin
      chk("m_conv_tdata", m_conv_tdata, mc.data);
      chk("m_conv_tid", DW'(m_conv_tid), DW'(mc.id));
      chk("m_conv_tlast", DW'(m_conv_tlast), DW'(mc.last));
    end
    if (tchk) begin
      chk("tbl_s0_tready", DW'(s0_tready), DW'(te0));
      chk("tbl_s1_tready", DW'(s1_tready), DW'(te1));
    end
    obs_acc = (s0_tready && s0_tvalid) || (s1_tready && s1_tvalid);
    obs_mv  = m_axis_tvalid;
    cyc     = ecount;
    a0 = e0 && s0_tvalid;
    a1 = e1 && s1_tvalid;
    pop = ev && m_axis_tready;
    l0 = s0_tlast; l1 = s1_tlast; d0 = s0_tdata; d1 = s1_tdata;
    @(posedge aclk);
    ecount++;
    if (pop) void'(q.pop_front());
    mc_v = a0 || a1;
    if (mc_v) begin
      f.id    = a1;
      f.last  = a1 ? l1 : l0;
      f.data  = a1 ? d1 : d0;
      f.avail = ecount + L + 1;
      q.push_back(f);
      mc = f;
      mlock = f.last ? -1 : int'(f.id);
      if (f.last) mlast = f.id;
    end
    @(negedge aclk);
  endtask

  task automatic idle(input int n);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc, first_mv, n_acc;
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    cycle();
    chk_reset_outputs();
    cycle();
    resetn = 1'b1;

    m_axis_tready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      s0_tvalid = tbl[i].s0v; s0_tlast = tbl[i].s0l; s0_tdata = 32'h1000 + i;
      s1_tvalid = tbl[i].s1v; s1_tlast = tbl[i].s1l; s1_tdata = 32'h2000 + i;
      cycle(1'b1, tbl[i].e0, tbl[i].e1);
    end
    idle(10);

    first_acc = -1;
    first_mv  = -1;
    for (int b = 0; b < 3; b++) begin
      s0_tvalid = 1'b1; s0_tlast = (b == 2); s0_tdata = $urandom;
      cycle();
      if (obs_acc && first_acc < 0) first_acc = cyc;
      if (obs_mv && first_mv < 0) first_mv = cyc;
    end
    s0_tvalid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_mv && first_mv < 0) first_mv = cyc;
    end
    chk("first_result_latency", DW'(first_mv - first_acc), DW'(4));

    m_axis_tready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = $urandom;
      cycle();
      if (obs_acc) n_acc++;
    end
    chk("stall_accepts", DW'(n_acc), DW'(D));
    chk("stall_s0_tready", DW'(s0_tready), '0);
    chk("stall_overflow", DW'(overflow), '0);
    m_axis_tready = 1'b1;
    cycle();
    m_axis_tready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      s0_tdata = $urandom;
      cycle();
      if (obs_acc) n_acc++;
    end
    chk("one_credit_accepts", DW'(n_acc), DW'(1));

    m_axis_tready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 24; i++) begin
      s0_tdata = $urandom; s0_tlast = (i == 23);
      cycle();
      if (obs_acc) n_acc++;
    end
    chk("full_stream_overflow", DW'(overflow), '0);
    chk("full_stream_progress", DW'(n_acc > 12), DW'(1));
    idle(12);

    for (int b = 0; b < 2; b++) begin
      s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 32'hA000 + b;
      cycle();
    end
    s0_tdata = 32'hA002;
    #2 resetn = 1'b0;
    #1 chk_reset_outputs();
    model_reset();
    cycle();
    resetn = 1'b1;
    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 32'hB000;
    s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 32'hB001;
    #1;
    chk("post_reset_s0_first", DW'(s0_tready), DW'(1));
    chk("post_reset_s1_blocked", DW'(s1_tready), '0);
    cycle();
    idle(12);

    for (int i = 0; i < 1500; i++) begin
      s0_tvalid = $urandom_range(0, 3) != 0;
      s0_tlast  = $urandom_range(0, 2) == 0;
      s0_tdata  = $urandom;
      s1_tvalid = $urandom_range(0, 3) != 0;
      s1_tlast  = $urandom_range(0, 2) == 0;
      s1_tdata  = $urandom;
      m_axis_tready = $urandom_range(0, 3) != 0;
      cycle();
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/attribute_f2x_scheduler.md
# attribute_f2x_scheduler

Shares one attribute float-to-fixed converter between two attribute interpolator fragment streams. It arbitrates round-robin, holding a grant for a whole packet (tlast-delimited). Fragments are issued into the converter, which has fixed latency and no backpressure. Results are collected in an output FIFO, and a credit scheme guarantees the FIFO never overflows under downstream stalls. The block sits between the interpolators and the pixel pipeline.

## Interface
- DATA_WIDTH, 32, packed fragment payload width (float attributes plus sideband).
- CONV_LATENCY, 2, converter input-to-output latency in cycles; must be at least 1.
- FIFO_DEPTH, 8, output FIFO entries; must be a power of 2 and at least CONV_LATENCY+2.
- aclk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s0_tvalid, s0_tready, s0_tlast, s0_tdata  in/out/in/in  1/1/1/DATA_WIDTH  requester 0 stream.
- s1_tvalid, s1_tready, s1_tlast, s1_tdata  in/out/in/in  1/1/1/DATA_WIDTH  requester 1 stream.
- m_conv_tvalid, m_conv_tlast, m_conv_tid, m_conv_tdata  out  1/1/1/DATA_WIDTH  registered issue port to the converter; tid is the source.
- s_conv_tvalid, s_conv_tlast, s_conv_tid, s_conv_tdata  in  1/1/1/DATA_WIDTH  converter result, arriving exactly CONV_LATENCY cycles after issue.
- m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tid, m_axis_tdata  out/in/out/out/out  1/1/1/1/DATA_WIDTH  output stream to the pixel pipeline.
- overflow  out  1  sticky error flag: a result arrived while the FIFO was full.

## Operation
- **Arbiter FSM states:** IDLE, LOCK0, LOCK1. A last_grant register is reset to 1, so s0 wins first.
- **Grant selection (combinational):**
  - LOCKn grants n.
  - IDLE with only one valid requester grants that requester.
  - IDLE with both valid grants the requester other than last_grant.
- **Credit:** occupancy = fifo_count + inflight. A credit is available when occupancy < FIFO_DEPTH.
- **Handshake:** sN_tready = granted(N) and credit. The other requester's tready is 0. tready never depends on the non-granted tvalid.
- **Transfer on grant n:**
  - Without tlast: next state is LOCKn.
  - With tlast: next state is IDLE and last_grant <= n.
  - In LOCKn, a tlast transfer returns to IDLE and sets last_grant <= n.
- **Issue register:** on transfer, m_conv_* <= {1, tlast, n, tdata} on the next edge. Otherwise m_conv_tvalid <= 0 and the data bits hold.
- **inflight counter:** width clog2(FIFO_DEPTH)+1. Incremented on transfer, decremented on s_conv_tvalid. A simultaneous increment and decrement leaves it unchanged.
- **FIFO write:** s_conv_tvalid writes {tlast, tid, tdata} unconditionally.
- **FIFO read:** occurs on m_axis_tvalid and m_axis_tready. The FIFO is first-word-fall-through: m_axis_tvalid = not empty, and the data is the head entry.
- **Simultaneous write and read when full:** allowed, with no overflow.
- **Write when full without a read:** the entry is dropped, count holds, and overflow <= 1 until reset. This is unreachable when the converter honours CONV_LATENCY.
- **FIFO pointers:** wrap modulo FIFO_DEPTH. fifo_count is pointer-difference based and never wraps past FIFO_DEPTH.
- **Reset (asynchronous):**
  - State IDLE, last_grant 1, inflight 0, FIFO empty, overflow 0.
  - m_conv_tvalid 0, m_conv_tlast 0, m_conv_tid 0, m_conv_tdata 0.
  - m_axis_tvalid 0, s0_tready 0, s1_tready 0.
  - Reset mid-packet discards all in-flight and buffered fragments. Converter results arriving after reset deassertion are ignored for CONV_LATENCY cycles, using a post-reset blanking counter.

## Timing
- Accept at edge k, then m_conv_tvalid high during cycle k+1.
- The result is written at edge k+1+CONV_LATENCY, so m_axis_tvalid is high from cycle k+2+CONV_LATENCY. That is 4 cycles with default parameters.
- Throughput: 1 fragment per cycle while credit is available and m_axis_tready=1.
- Single-beat packets from both requesters alternate every cycle with no idle bubbles.
- With m_axis_tready held 0, exactly FIFO_DEPTH fragments are accepted, then tready drops. One credit returns per cycle after tready rises.

## Test plan
- **Single requester:** s0 sends 3 beats (tlast on beat 3) with m_axis_tready=1. Expect m_axis beats with tid=0, tlast only on the 3rd beat, and the first beat 4 cycles after the first accept.
- **Round-robin:** both valid, single-beat packets. Expect grant order s0,s1,s0,s1, one accept per cycle, and m_axis_tid alternating 0,1,0,1.
- **Packet lock:** s0 sends a 4-beat packet while s1 holds valid. Expect s1_tready=0 for all 4 beats and s1 granted the cycle after s0's tlast.
- **Backpressure:** m_axis_tready=0 with s0 streaming. Expect exactly 8 accepts, then s0_tready=0, overflow=0. Raise tready for one cycle: expect exactly one more accept, 4 cycles later.
- **Full plus simultaneous read/write:** FIFO at 8 and tready=1 with a continuous stream. Expect count steady, no overflow, and data order preserved.
- **Reset mid-packet:** assert resetn=0 asynchronously during beat 2 of a packet. Expect all outputs at reset values immediately. After release, s0 is granted first and no stale beats appear on m_axis.
